// File: rtl/quad_decoder_if.sv
// Bundles the encoder inputs, control strobes and decoded outputs of quad_decoder.
// The master drives encoder and control signals; the slave (the decoder) returns position/status.
interface quad_decoder_if #(
    parameter int CNT_W = 16
);
    logic             enc_a;
    logic             enc_b;
    logic             en;
    logic             clr;
    logic             err_clr;
    logic [CNT_W-1:0] count;
    logic             dir;
    logic             step_pulse;
    logic             err;

    modport master (
        output enc_a, enc_b, en, clr, err_clr,
        input  count, dir, step_pulse, err
    );

    modport slave (
        input  enc_a, enc_b, en, clr, err_clr,
        output count, dir, step_pulse, err
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and glitch-filters the A/B channels, decodes Gray-code
// transitions into up/down steps, keeps a wrapping position count and a sticky illegal-move flag.
module quad_decoder #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input logic            clk,
    input logic            rst,
    quad_decoder_if.slave  bus
);
    localparam int INIT_LEN = SYNC_STAGES + 1;
    localparam int INIT_W   = $clog2(INIT_LEN + 1);
    localparam int FCNT_W   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [SYNC_STAGES-1:0]  sync_a;
    logic [SYNC_STAGES-1:0]  sync_b;
    logic [1:0]              sync_out;
    logic [INIT_W-1:0]       init_cnt;
    logic                    init_done;
    logic [1:0]              filt;
    logic [1:0]              prev;
    logic [1:0][FCNT_W-1:0]  fcnt;
    logic                    step_up;
    logic                    step_dn;
    logic                    illegal;
    logic [CNT_W-1:0]        count_q;
    logic                    dir_q;
    logic                    step_q;
    logic                    err_q;

    assign sync_out  = {sync_b[SYNC_STAGES-1], sync_a[SYNC_STAGES-1]};
    assign init_done = (init_cnt == INIT_W'(INIT_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a   <= '0;
            sync_b   <= '0;
            init_cnt <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], bus.enc_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], bus.enc_b};
            if (!init_done)
                init_cnt <= init_cnt + INIT_W'(1);
        end
    end

    // During init both filtered and previous state track the synchronizer directly,
    // so an encoder resting at a nonzero position does not look like a move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= '0;
            prev <= '0;
            fcnt <= '0;
        end else if (!init_done) begin
            filt <= sync_out;
            prev <= sync_out;
            fcnt <= '0;
        end else begin
            prev <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync_out[i] != filt[i]) begin
                    if (fcnt[i] == FCNT_W'(FILT_LEN - 1)) begin
                        filt[i] <= sync_out[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + FCNT_W'(1);
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    // {B,A} transitions: up runs 00->01->11->10->00, down is the reverse, both bits changing is illegal.
    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        illegal = 1'b0;
        case ({prev, filt})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_up = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_dn = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
            default: ;
        endcase
    end

    // clr beats a simultaneous step on the count only; an illegal move beats err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            step_q <= 1'b0;
            if (init_done && bus.en && (step_up || step_dn)) begin
                step_q <= 1'b1;
                dir_q  <= step_up;
            end
            if (bus.clr)
                count_q <= '0;
            else if (init_done && bus.en && step_up)
                count_q <= count_q + CNT_W'(1);
            else if (init_done && bus.en && step_dn)
                count_q <= count_q - CNT_W'(1);
            if (init_done && illegal)
                err_q <= 1'b1;
            else if (bus.err_clr)
                err_q <= 1'b0;
        end
    end

    assign bus.count      = count_q;
    assign bus.dir        = dir_q;
    assign bus.step_pulse = step_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios followed by a random walk,
// all checked against a position-based model of the encoder.
module tb_quad_decoder;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   pulse_cnt;
    int   exp_pulses;
    int   pos;
    logic [15:0] exp_count;
    logic        exp_dir;

    quad_decoder_if #(.CNT_W(16)) qif ();

    quad_decoder #(.CNT_W(16), .SYNC_STAGES(2), .FILT_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (qif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (qif.step_pulse === 1'b1)
            pulse_cnt++;
    end

    // Encoder position maps to {B,A} through the Gray sequence 00,01,11,10.
    function automatic logic [1:0] gray(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] st, input int cycles);
        {qif.enc_b, qif.enc_a} = st;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic model_step(input int delta);
        if (qif.en) begin
            exp_count  = exp_count + 16'(delta);
            exp_dir    = (delta > 0);
            exp_pulses++;
        end
    endtask

    task automatic move(input int delta, input int hold);
        pos += delta;
        model_step(delta);
        apply_stimulus(gray(pos), hold);
    endtask

    task automatic check_state(input string tag);
        check_output({tag, "_count"}, 32'(qif.count), 32'(exp_count));
        check_output({tag, "_dir"}, 32'(qif.dir), 32'(exp_dir));
        check_output({tag, "_pulses"}, 32'(pulse_cnt), 32'(exp_pulses));
    endtask

    initial begin
        total = 0; bad = 0; pulse_cnt = 0; exp_pulses = 0;
        exp_count = '0; exp_dir = 1'b0;
        qif.en = 1'b1; qif.clr = 1'b0; qif.err_clr = 1'b0;
        pos = 2;
        {qif.enc_b, qif.enc_a} = 2'b11;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_count", 32'(qif.count), 32'd0);
        check_output("rst_dir", 32'(qif.dir), 32'd0);
        check_output("rst_step", 32'(qif.step_pulse), 32'd0);
        check_output("rst_err", 32'(qif.err), 32'd0);

        $display("[TB] encoder resting at 11 through init");
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_state("init11");
        check_output("init11_err", 32'(qif.err), 32'd0);

        move(1, 10);
        move(1, 10);
        qif.clr = 1'b1;
        @(posedge clk); #1;
        qif.clr = 1'b0;
        exp_count = '0;
        check_output("clr_count", 32'(qif.count), 32'd0);

        $display("[TB] up sequence with latency check");
        pos = 9;
        {qif.enc_b, qif.enc_a} = gray(pos);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check_output("lat_before", 32'(qif.count), 32'd0);
        @(posedge clk); #1;
        model_step(1);
        check_output("lat_count", 32'(qif.count), 32'd1);
        check_output("lat_pulse", 32'(qif.step_pulse), 32'd1);
        @(posedge clk); #1;
        check_output("lat_pulse_end", 32'(qif.step_pulse), 32'd0);
        repeat (2) @(posedge clk); #1;
        move(1, 10);
        move(1, 10);
        move(1, 10);
        check_state("up4");
        check_output("up4_val", 32'(qif.count), 32'd4);

        $display("[TB] wrap below zero and back");
        qif.clr = 1'b1;
        @(posedge clk); #1;
        qif.clr = 1'b0;
        exp_count = '0;
        move(-1, 10);
        check_state("wrap_dn");
        check_output("wrap_dn_val", 32'(qif.count), 32'hFFFF);
        move(1, 10);
        check_state("wrap_up");

        $display("[TB] glitch rejection");
        apply_stimulus(2'b01, 3);
        apply_stimulus(2'b00, 10);
        check_state("glitch3");
        apply_stimulus(2'b01, 4);
        {qif.enc_b, qif.enc_a} = 2'b00;
        repeat (3) @(posedge clk); #1;
        check_output("glitch4_mid", 32'(qif.count), 32'd1);
        repeat (7) @(posedge clk); #1;
        exp_pulses += 2;
        exp_dir = 1'b0;
        check_state("glitch4");

        $display("[TB] illegal transitions");
        apply_stimulus(2'b11, 10);
        check_output("ill1_err", 32'(qif.err), 32'd1);
        check_state("ill1");
        {qif.enc_b, qif.enc_a} = 2'b00;
        repeat (6) @(posedge clk); #1;
        qif.err_clr = 1'b1;
        @(posedge clk); #1;
        qif.err_clr = 1'b0;
        check_output("ill2_err", 32'(qif.err), 32'd1);
        repeat (3) @(posedge clk); #1;
        check_state("ill2");
        qif.err_clr = 1'b1;
        @(posedge clk); #1;
        qif.err_clr = 1'b0;
        check_output("errclr_err", 32'(qif.err), 32'd0);

        $display("[TB] clr colliding with a step");
        pos = 8;
        move(1, 10);
        check_state("pre_clr");
        pos = 10;
        {qif.enc_b, qif.enc_a} = gray(pos);
        repeat (6) @(posedge clk); #1;
        qif.clr = 1'b1;
        @(posedge clk); #1;
        qif.clr = 1'b0;
        exp_pulses++;
        exp_dir = 1'b1;
        exp_count = '0;
        check_output("clrstep_count", 32'(qif.count), 32'd0);
        check_output("clrstep_pulse", 32'(qif.step_pulse), 32'd1);
        check_output("clrstep_dir", 32'(qif.dir), 32'd1);
        repeat (3) @(posedge clk); #1;

        $display("[TB] async reset mid-run");
        for (int i = 0; i < 7; i++)
            move(1, 10);
        check_output("pre_rst_count", 32'(qif.count), 32'd7);
        pos = 19;
        apply_stimulus(gray(pos), 10);
        check_output("pre_rst_err", 32'(qif.err), 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_output("arst_count", 32'(qif.count), 32'd0);
        check_output("arst_err", 32'(qif.err), 32'd0);
        check_output("arst_dir", 32'(qif.dir), 32'd0);
        check_output("arst_step", 32'(qif.step_pulse), 32'd0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        exp_count = '0;
        exp_dir = 1'b0;
        repeat (10) @(posedge clk); #1;
        check_state("reinit");
        check_output("reinit_err", 32'(qif.err), 32'd0);

        $display("[TB] random walk");
        for (int i = 0; i < 40; i++) begin
            qif.en = ($urandom_range(3) != 0);
            move(($urandom_range(1) == 1) ? 1 : -1, 8 + $urandom_range(6));
            check_state("rand");
        end
        check_output("rand_err", 32'(qif.err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
